// File: rtl/mdio_peripheral_ctrl_if.sv
// mdio_peripheral_ctrl_if
// Purpose: bundles the MDIO serial pins and the register-file port of the
//          Clause-22 MDIO peripheral sequencer.
// Signals:
//   mdc, mdio_in      host management clock and serial data (host -> peripheral)
//   mdio_out, mdio_oe serial read data and its output enable (peripheral -> host)
//   addr, wr_data     register-file address and write data
//   wr_stb            one-clk register-file write strobe
//   rd_data           register-file read data, combinational on addr
//   busy, frame_err   frame-in-progress flag and malformed-frame pulse
// Modports: slave = peripheral side, master = host / register-file side.
interface mdio_peripheral_ctrl_if;
   logic        mdc;
   logic        mdio_in;
   logic        mdio_out;
   logic        mdio_oe;
   logic [4:0]  addr;
   logic [15:0] wr_data;
   logic        wr_stb;
   logic [15:0] rd_data;
   logic        busy;
   logic        frame_err;

   modport slave (
      input  mdc, mdio_in, rd_data,
      output mdio_out, mdio_oe, addr, wr_data, wr_stb, busy, frame_err
   );

   modport master (
      output mdc, mdio_in, rd_data,
      input  mdio_out, mdio_oe, addr, wr_data, wr_stb, busy, frame_err
   );
endinterface

// File: rtl/mdio_peripheral_ctrl.sv
// mdio_peripheral_ctrl
// Purpose: decodes Clause-22 MDIO frames sampled from MDC/MDIO_IN on the system
//          clock, drives register-file writes and serialises read data back.
//          clk must run at least 4x MDC.
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   io_bus   slave modport: MDIO pins and register-file port
module mdio_peripheral_ctrl #(
   parameter logic [4:0]  PHY_ADDR     = 5'd0,
   parameter int unsigned PREAMBLE_LEN = 32
) (
   input logic                   i_clk,
   input logic                   i_rst_n,
   mdio_peripheral_ctrl_if.slave io_bus
);

   localparam int unsigned PreW = $clog2(PREAMBLE_LEN + 1);
   localparam logic [PreW-1:0] PreMax = PreW'(PREAMBLE_LEN);

   typedef enum logic [2:0] {
      StIdle, StSt2, StOp, StPhyad, StRegad, StTa, StData
   } state_t;

   state_t          r_state;
   logic [2:0]      r_mdc_sync;   // [1:0] synchroniser, [2] previous sample
   logic [1:0]      r_mdio_sync;
   logic [PreW-1:0] r_pre_cnt;
   logic [4:0]      r_cnt;
   logic [15:0]     r_shift;
   logic            r_is_read;
   logic            r_match;
   logic            r_ta0;
   logic            r_mdio_out;
   logic            r_mdio_oe;
   logic [4:0]      r_addr;
   logic [15:0]     r_wr_data;
   logic            r_wr_stb;
   logic            r_frame_err;

   logic            w_bit;
   logic            w_din;
   logic [15:0]     w_shift_in;

   assign w_bit      = r_mdc_sync[1] & ~r_mdc_sync[2];
   assign w_din      = r_mdio_sync[1];
   assign w_shift_in = {r_shift[14:0], w_din};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_mdc_sync  <= '0;
         r_mdio_sync <= '0;
         r_pre_cnt   <= '0;
         r_cnt       <= '0;
         r_shift     <= '0;
         r_is_read   <= 1'b0;
         r_match     <= 1'b0;
         r_ta0       <= 1'b0;
         r_mdio_out  <= 1'b0;
         r_mdio_oe   <= 1'b0;
         r_addr      <= '0;
         r_wr_data   <= '0;
         r_wr_stb    <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_mdc_sync  <= {r_mdc_sync[1:0], io_bus.mdc};
         r_mdio_sync <= {r_mdio_sync[0], io_bus.mdio_in};
         r_wr_stb    <= 1'b0;
         r_frame_err <= 1'b0;
         if (w_bit) begin
            // Every field is collected MSB first through the shared shift register.
            r_shift <= w_shift_in;
            r_cnt   <= r_cnt + 5'd1;
            case (r_state)
               StIdle: begin
                  r_cnt <= '0;
                  if (w_din) begin
                     if (r_pre_cnt != PreMax) r_pre_cnt <= r_pre_cnt + 1'b1;
                  end else begin
                     r_pre_cnt <= '0;
                     if (r_pre_cnt == PreMax) r_state <= StSt2;
                  end
               end
               StSt2: begin
                  r_cnt <= '0;
                  if (w_din) begin
                     r_state <= StOp;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= StIdle;
                  end
               end
               StOp: begin
                  if (r_cnt == 5'd1) begin
                     r_cnt <= '0;
                     case (w_shift_in[1:0])
                        2'b01: begin
                           r_is_read <= 1'b0;
                           r_state   <= StPhyad;
                        end
                        2'b10: begin
                           r_is_read <= 1'b1;
                           r_state   <= StPhyad;
                        end
                        default: begin
                           r_frame_err <= 1'b1;
                           r_state     <= StIdle;
                        end
                     endcase
                  end
               end
               StPhyad: begin
                  if (r_cnt == 5'd4) begin
                     r_cnt   <= '0;
                     r_match <= (w_shift_in[4:0] == PHY_ADDR);
                     r_state <= StRegad;
                  end
               end
               StRegad: begin
                  if (r_cnt == 5'd4) begin
                     r_cnt   <= '0;
                     if (r_match) r_addr <= w_shift_in[4:0];
                     r_state <= StTa;
                  end
               end
               StTa: begin
                  if (r_cnt == 5'd0) begin
                     r_ta0 <= w_din;
                  end else begin
                     r_cnt   <= '0;
                     r_state <= StData;
                     if (r_is_read) begin
                        if (r_match) begin
                           // ADDR settled at the end of REGAD, so RD_DATA is valid here.
                           r_mdio_oe  <= 1'b1;
                           r_mdio_out <= 1'b0;
                           r_shift    <= io_bus.rd_data;
                        end
                     end else if (r_match && !(r_ta0 && !w_din)) begin
                        r_frame_err <= 1'b1;
                        r_state     <= StIdle;
                     end
                  end
               end
               StData: begin
                  if (r_is_read && r_match) begin
                     // 16 shift-out events plus one release event.
                     if (r_cnt == 5'd16) begin
                        r_cnt      <= '0;
                        r_mdio_oe  <= 1'b0;
                        r_mdio_out <= 1'b0;
                        r_state    <= StIdle;
                     end else begin
                        r_mdio_out <= r_shift[15];
                        r_shift    <= {r_shift[14:0], 1'b0};
                     end
                  end else if (r_cnt == 5'd15) begin
                     r_cnt   <= '0;
                     r_state <= StIdle;
                     if (!r_is_read && r_match) begin
                        r_wr_data <= w_shift_in;
                        r_wr_stb  <= 1'b1;
                     end
                  end
               end
               default: begin
                  r_cnt   <= '0;
                  r_state <= StIdle;
               end
            endcase
         end
      end
   end

   assign io_bus.mdio_out  = r_mdio_out;
   assign io_bus.mdio_oe   = r_mdio_oe;
   assign io_bus.addr      = r_addr;
   assign io_bus.wr_data   = r_wr_data;
   assign io_bus.wr_stb    = r_wr_stb;
   assign io_bus.busy      = (r_state != StIdle);
   assign io_bus.frame_err = r_frame_err;

endmodule

// File: doc/mdio_peripheral_ctrl.md
Name: mdio_peripheral_ctrl

Overview:
Management-side sequencer for the PHY register file. It decodes Clause-22 MDIO frames arriving serially on MDC/MDIO_IN, drives the register file's ADDR/WR_DATA/WR_STB port, and serialises RD_DATA back onto MDIO. Everything runs on the system clk; MDC is oversampled and edge-detected, so clk must be at least 4x MDC.

Parameters:
PHY_ADDR, 5'd0, PHYAD value this peripheral answers to.
PREAMBLE_LEN, 32, consecutive 1 bits required before a start of frame is accepted.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
MDC  in  1  management clock from the host; sampled with clk
MDIO_IN  in  1  serial data from the host
MDIO_OUT  out  1  serial read data to the host
MDIO_OE  out  1  1 = peripheral drives MDIO
ADDR  out  5  register address to the register file
WR_DATA  out  16  write data to the register file
WR_STB  out  1  one-clk write strobe
RD_DATA  in  16  read data from the register file (combinational on ADDR)
BUSY  out  1  1 = frame in progress (any state other than IDLE)
FRAME_ERR  out  1  one-clk pulse on a malformed frame

Behaviour:
- Reset values: MDIO_OUT=0, MDIO_OE=0, ADDR=0, WR_DATA=0, WR_STB=0, BUSY=0, FRAME_ERR=0. State=IDLE, all counters=0.
- Synchronisation:
  - MDC and MDIO_IN pass through 2-flop synchronisers.
  - A bit event is a detected MDC rising edge: sync'd MDC=1 and previous sample=0.
  - MDIO_IN is captured on that same clk.
  - All actions below happen only on bit events, except WR_STB/FRAME_ERR deassertion.
- Bit order: MSB first for every field.
- State IDLE:
  - Count consecutive 1s, saturating at PREAMBLE_LEN. A 0 clears the count.
  - A 0 seen while count==PREAMBLE_LEN moves to ST2 (this 0 is ST bit 1).
- ST2: bit must be 1, then go to OP. If 0, pulse FRAME_ERR and go to IDLE.
- OP: collect 2 bits.
  - 01 = write, 10 = read.
  - 00 or 11: pulse FRAME_ERR, go to IDLE.
- PHYAD: collect 5 bits. Set match flag = (PHYAD == PHY_ADDR).
- REGAD: collect 5 bits.
  - On the 5th bit, if match: ADDR <= REGAD.
  - ADDR holds until the next matched frame.
- TA, read with match:
  - On the first TA bit event: MDIO_OE stays 0 (high-Z).
  - On the second TA bit event: MDIO_OE=1, MDIO_OUT=0.
  - Then latch shift register <= RD_DATA.
- TA, write:
  - Sampled TA bits must be 1,0. Otherwise pulse FRAME_ERR and go to IDLE with no write.
- DATA, read:
  - On each of the next 16 bit events, MDIO_OUT <= shift[15] and shift left.
  - MDIO_OUT changes within 1 clk after the synchronised MDC rise, so the host samples it on the following MDC rise.
  - On the bit event after the 16th: MDIO_OE=0, MDIO_OUT=0, go to IDLE.
- DATA, write: collect 16 bits into WR_DATA.
  - After the 16th bit, if match: WR_STB=1 for exactly one clk, with ADDR=REGAD and WR_DATA stable.
  - Then go to IDLE.
- PHYAD mismatch:
  - Run through TA and DATA, counting bits.
  - MDIO_OE stays 0, no WR_STB, no ADDR change, no FRAME_ERR.
  - Return to IDLE after 16 data bits.
- Preamble counting: restarts from 0 on return to IDLE. Back-to-back frames therefore each need a full preamble.
- Asynchronous reset mid-frame: all outputs return to reset values immediately, and any pending write is discarded.
- MDC stalled: state holds indefinitely. There is no timeout.

Test Plan:
- Write ADDR 5'h03 with 16'hA5C3 (PHY_ADDR=0, 32-bit preamble) -> one WR_STB pulse, ADDR=03, WR_DATA=A5C3, FRAME_ERR=0, BUSY=0 afterwards.
- Read ADDR 5'h03 with RD_DATA=16'hA5C3 -> MDIO_OE low for TA1, high from TA2; host samples 0 then A5C3 MSB-first; MDIO_OE=0 after bit 16.
- Frame to PHYAD 5'h07 (PHY_ADDR=0), write 16'hFFFF -> no WR_STB, MDIO_OE never 1, ADDR unchanged; a following valid frame to PHYAD 0 is accepted.
- Only 31 preamble ones, then 01 -> frame ignored: no strobe, no FRAME_ERR. Same frame with 32 ones -> accepted.
- OP=11, then separately a write with TA=11 -> FRAME_ERR one-clk pulse each time, no WR_STB, BUSY returns to 0.
- reset=0 during bit 8 of a read data phase -> MDIO_OE=0 and all outputs at reset values within the same cycle; after release, a full write to ADDR 5'h1F with 16'h1234 succeeds.
